// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter sizing helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full
// subtractor cell with a registered borrow; start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] d_sh_reg, d_sh_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             bin_reg, bin_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             borrow_reg, borrow_next;

  logic             d_bit;
  logic             bout_bit;
  logic [WIDTH-1:0] d_shifted;

  full_subtractor u_cell (
    .x    (a_sh_reg[0]),
    .y    (b_sh_reg[0]),
    .bin  (bin_reg),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // New bit enters at the MSB so the LSB-first result lands in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign d_shifted = d_bit;
    end else begin : g_wn
      assign d_shifted = {d_bit, d_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      d_sh_reg   <= '0;
      cnt_reg    <= '0;
      bin_reg    <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      d_sh_reg   <= d_sh_next;
      cnt_reg    <= cnt_next;
      bin_reg    <= bin_next;
      diff_reg   <= diff_next;
      borrow_reg <= borrow_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    d_sh_next   = d_sh_reg;
    cnt_next    = cnt_reg;
    bin_next    = bin_reg;
    diff_next   = diff_reg;
    borrow_next = borrow_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          a_sh_next  = bus.a;
          b_sh_next  = bus.b;
          d_sh_next  = '0;
          cnt_next   = '0;
          bin_next   = 1'b0;
        end
      end
      RUN: begin
        d_sh_next = d_shifted;
        a_sh_next = a_sh_reg >> 1;
        b_sh_next = b_sh_reg >> 1;
        bin_next  = bout_bit;
        cnt_next  = cnt_reg + 1'b1;
        // Ports only update on the final bit, never with partial results.
        if (cnt_reg == LAST_BIT) begin
          state_next  = DONE;
          diff_next   = d_shifted;
          borrow_next = bout_bit;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 13 and 1: fixed vectors, handshake
// corner cases and random operands against an arithmetic reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(13)) bus13 ();
  serial_subtractor_if #(.WIDTH(1))  bus1 ();

  serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(13)) u13 (.clk(clk), .rst(rst), .bus(bus13));
  serial_subtractor #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      8:  begin bus8.start = s;  bus8.a = a[7:0];   bus8.b = b[7:0];   end
      13: begin bus13.start = s; bus13.a = a[12:0]; bus13.b = b[12:0]; end
      default: begin bus1.start = s; bus1.a = a[0]; bus1.b = b[0]; end
    endcase
  endtask

  function automatic logic rd_done(input int sel);
    case (sel)
      8:  return bus8.done;
      13: return bus13.done;
      default: return bus1.done;
    endcase
  endfunction

  function automatic logic rd_busy(input int sel);
    case (sel)
      8:  return bus8.busy;
      13: return bus13.busy;
      default: return bus1.busy;
    endcase
  endfunction

  function automatic logic [31:0] rd_diff(input int sel);
    case (sel)
      8:  return 32'(bus8.diff);
      13: return 32'(bus13.diff);
      default: return 32'(bus1.diff);
    endcase
  endfunction

  function automatic logic rd_borrow(input int sel);
    case (sel)
      8:  return bus8.borrow_out;
      13: return bus13.borrow_out;
      default: return bus1.borrow_out;
    endcase
  endfunction

  // Reference: unsigned subtraction modulo 2^width, borrow iff a < b.
  function automatic logic [31:0] ref_diff(input int w, input logic [31:0] a, input logic [31:0] b);
    longint m = longint'(1) << w;
    longint d = (longint'(a) - longint'(b)) % m;
    if (d < 0) d += m;
    return 32'(d);
  endfunction

  // One transaction; expects done WIDTH edges after the accepting edge.
  task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_d, input logic exp_bo,
                     input bit scramble, input string tag);
    int n;
    int busy_cycles;
    bit seen;
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b);
    busy_cycles = int'(rd_busy(sel));
    seen = 1'b0;
    n = 0;
    while (!seen && n < sel + 4) begin
      n++;
      if (scramble && n == 3) drive(sel, 1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      busy_cycles += int'(rd_busy(sel));
      if (rd_done(sel)) seen = 1'b1;
    end
    if (!seen) begin
      check($sformatf("%s done timeout", tag), 32'd0, 32'd1);
      return;
    end
    check($sformatf("%s latency", tag), 32'(n), 32'(sel));
    check($sformatf("%s diff", tag), rd_diff(sel), exp_d);
    check($sformatf("%s borrow_out", tag), 32'(rd_borrow(sel)), 32'(exp_bo));
    check($sformatf("%s busy cycles", tag), 32'(busy_cycles), 32'(sel + 1));
    @(posedge clk); #1;
    check($sformatf("%s done pulse width", tag), 32'(rd_done(sel)), 32'd0);
    check($sformatf("%s busy after", tag), 32'(rd_busy(sel)), 32'd0);
    $display("w=%0d %s a=%0d b=%0d diff=%0d borrow=%0d", sel, tag, a, b, rd_diff(sel), rd_borrow(sel));
  endtask

  initial begin
    int pulses;
    int last;
    int cnt;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0] = '{8, 100, 37, 63, 1'b0};
    tbl[1] = '{8, 5, 10, 251, 1'b1};
    tbl[2] = '{8, 0, 255, 1, 1'b1};
    tbl[3] = '{8, 255, 0, 255, 1'b0};
    tbl[4] = '{8, 0, 0, 0, 1'b0};
    tbl[5] = '{1, 0, 1, 1, 1'b1};
    tbl[6] = '{1, 1, 1, 0, 1'b0};
    tbl[7] = '{13, 8191, 1, 8190, 1'b0};
    tbl[8] = '{13, 0, 1, 8191, 1'b1};
    tbl[9] = '{8, 128, 129, 255, 1'b1};

    rst = 1'b1;
    drive(8, 1'b1, 32'd9, 32'd3);
    drive(13, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus8.busy), 32'd0);
    check("reset done", 32'(bus8.done), 32'd0);
    check("reset diff", 32'(bus8.diff), 32'd0);
    check("reset borrow_out", 32'(bus8.borrow_out), 32'd0);
    drive(8, 1'b0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, 1'b0, $sformatf("table%0d", i));

    run(8, 100, 37, 63, 1'b0, 1'b1, "scrambled-inputs");

    // Held start: one result every WIDTH+2 cycles, no starts taken while busy.
    drive(8, 1'b1, 32'd20, 32'd3);
    pulses = 0;
    last = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        check("held diff", 32'(bus8.diff), 32'd17);
        check("held borrow_out", 32'(bus8.borrow_out), 32'd0);
        if (last != 0) check("held period", 32'(cyc - last), 32'd10);
        last = cyc;
        pulses++;
      end
    end
    check("held pulse count", 32'(pulses), 32'd4);
    $display("w=8 held-start pulses=%0d", pulses);
    drive(8, 1'b0, 32'd20, 32'd3);
    cnt = 0;
    while (bus8.busy && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("held drain idle", 32'(bus8.busy), 32'd0);

    // Reset at edge 4 of a run aborts it without a done pulse.
    run(8, 100, 37, 63, 1'b0, 1'b0, "pre-reset");
    drive(8, 1'b1, 32'd200, 32'd50);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'd200, 32'd50);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(bus8.busy), 32'd0);
    check("abort done", 32'(bus8.done), 32'd0);
    check("abort diff", 32'(bus8.diff), 32'd0);
    check("abort borrow_out", 32'(bus8.borrow_out), 32'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (bus8.done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    $display("w=8 reset-abort done_after=%0d", pulses);
    run(8, 200, 50, 150, 1'b0, 1'b0, "post-reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      run(8, ra, rb, ref_diff(8, ra, rb), ra < rb, 1'b0, "rand");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 32'($urandom_range(0, 8191));
      rb = 32'($urandom_range(0, 8191));
      run(13, ra, rb, ref_diff(13, ra, rb), ra < rb, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
